// File: rtl/eth_tx_sched_pkg.sv
// rtl/eth_tx_sched_pkg.sv - shared constants, state type and helpers for the tx frame scheduler
package eth_tx_sched_pkg;

    localparam logic [10:0] PAKET_MAX_SIZE = 11'd1500;
    localparam logic [7:0]  IFG_CYCLES     = 8'd48;
    localparam logic [2:0]  BUSY_WAIT      = 3'd4;
    localparam logic [15:0] DONE_TIMEOUT   = 16'd4000;

    localparam int RMII_BITS_PER_CLK = 2;
    localparam int IFG_BIT_TIMES     = 96;

    // Counters start at 0 on state entry, so each limit is compared as count-1.
    localparam logic [15:0] BUSY_LIMIT = 16'(BUSY_WAIT) - 16'd1;
    localparam logic [15:0] DONE_LIMIT = DONE_TIMEOUT - 16'd1;
    localparam logic [15:0] IFG_LIMIT  = 16'(IFG_CYCLES) - 16'd1;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_START     = 3'd1,
        ST_WAIT_BUSY = 3'd2,
        ST_WAIT_DONE = 3'd3,
        ST_IFG       = 3'd4
    } sched_state_t;

    function automatic logic size_valid(input logic [10:0] size);
        return (size != 11'd0) && (size <= PAKET_MAX_SIZE);
    endfunction

    function automatic logic [1:0] src_onehot(input logic idx);
        return idx ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/eth_tx_sched_if.sv
// rtl/eth_tx_sched_if.sv - requester and engine signals of the tx frame scheduler
interface eth_tx_sched_if;

    logic [1:0]  i_req;
    logic [10:0] i_size0;
    logic [10:0] i_size1;
    logic [1:0]  o_ack;
    logic [1:0]  o_err;
    logic        o_busy;
    logic        o_grant;
    logic        o_tx_en;
    logic [10:0] o_tx_size;
    logic        o_ram_bank;
    logic        i_tx_ready;

    modport slave (
        input  i_req, i_size0, i_size1, i_tx_ready,
        output o_ack, o_err, o_busy, o_grant, o_tx_en, o_tx_size, o_ram_bank
    );

    modport master (
        output i_req, i_size0, i_size1, i_tx_ready,
        input  o_ack, o_err, o_busy, o_grant, o_tx_en, o_tx_size, o_ram_bank
    );

endinterface

// File: rtl/eth_tx_sched.sv
// rtl/eth_tx_sched.sv - two-source round-robin frame scheduler in front of eth_tx
module eth_tx_sched
    import eth_tx_sched_pkg::*;
(
    input  logic          i_clk,
    input  logic          i_rst_n,
    eth_tx_sched_if.slave io_bus
);

    sched_state_t r_state;
    logic         r_rr;
    logic [15:0]  r_cnt;
    logic [1:0]   r_ack;
    logic [1:0]   r_err;
    logic         r_busy;
    logic         r_grant;
    logic         r_tx_en;
    logic [10:0]  r_tx_size;

    logic         w_any_req;
    logic         w_pick;
    logic [10:0]  w_pick_size;

    // A lone requester always wins; on contention the rr pointer decides.
    always_comb begin
        w_any_req = |io_bus.i_req;
        case (io_bus.i_req)
            2'b01:   w_pick = 1'b0;
            2'b10:   w_pick = 1'b1;
            default: w_pick = r_rr;
        endcase
        w_pick_size = w_pick ? io_bus.i_size1 : io_bus.i_size0;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state   <= ST_IDLE;
            r_rr      <= 1'b0;
            r_cnt     <= 16'd0;
            r_ack     <= 2'b00;
            r_err     <= 2'b00;
            r_busy    <= 1'b0;
            r_grant   <= 1'b0;
            r_tx_en   <= 1'b0;
            r_tx_size <= 11'd0;
        end else begin
            r_ack   <= 2'b00;
            r_err   <= 2'b00;
            r_tx_en <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_any_req && io_bus.i_tx_ready) begin
                        r_grant   <= w_pick;
                        r_tx_size <= w_pick_size;
                        if (!size_valid(w_pick_size)) begin
                            r_err <= src_onehot(w_pick);
                            r_rr  <= ~w_pick;
                        end else begin
                            r_busy  <= 1'b1;
                            r_tx_en <= 1'b1;
                            r_state <= ST_START;
                        end
                    end
                end
                ST_START: begin
                    r_cnt   <= 16'd0;
                    r_state <= ST_WAIT_BUSY;
                end
                ST_WAIT_BUSY: begin
                    if (!io_bus.i_tx_ready) begin
                        r_cnt   <= 16'd0;
                        r_state <= ST_WAIT_DONE;
                    end else if (r_cnt == BUSY_LIMIT) begin
                        r_err   <= src_onehot(r_grant);
                        r_cnt   <= 16'd0;
                        r_state <= ST_IFG;
                    end else begin
                        r_cnt <= r_cnt + 16'd1;
                    end
                end
                ST_WAIT_DONE: begin
                    if (io_bus.i_tx_ready) begin
                        r_ack   <= src_onehot(r_grant);
                        r_cnt   <= 16'd0;
                        r_state <= ST_IFG;
                    end else if (r_cnt == DONE_LIMIT) begin
                        r_err   <= src_onehot(r_grant);
                        r_cnt   <= 16'd0;
                        r_state <= ST_IFG;
                    end else begin
                        r_cnt <= r_cnt + 16'd1;
                    end
                end
                ST_IFG: begin
                    if (r_cnt == IFG_LIMIT) begin
                        r_busy  <= 1'b0;
                        r_rr    <= ~r_grant;
                        r_cnt   <= 16'd0;
                        r_state <= ST_IDLE;
                    end else begin
                        r_cnt <= r_cnt + 16'd1;
                    end
                end
                default: begin
                    r_cnt   <= 16'd0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign io_bus.o_ack      = r_ack;
    assign io_bus.o_err      = r_err;
    assign io_bus.o_busy     = r_busy;
    assign io_bus.o_grant    = r_grant;
    assign io_bus.o_tx_en    = r_tx_en;
    assign io_bus.o_tx_size  = r_tx_size;
    assign io_bus.o_ram_bank = r_grant;

endmodule

// File: tb/tb_eth_tx_sched.sv
// tb/tb_eth_tx_sched.sv - self-checking bench for eth_tx_sched
module tb_eth_tx_sched;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req0 = 1'b0;
    logic        req1 = 1'b0;
    logic [10:0] size0 = 11'd0;
    logic [10:0] size1 = 11'd0;
    logic        eng_ready = 1'b1;
    int          eng_mode = 0;
    int          eng_len = 20;
    int          eng_left = 0;
    bit          eng_rand = 1'b0;

    int n_checks = 0;
    int n_fail = 0;
    int cyc = 0;
    int n_tx_en = 0;

    logic [1:0]  m_ack = 2'b00;
    logic [1:0]  m_err = 2'b00;
    logic        m_busy = 1'b0;
    logic        m_grant = 1'b0;
    logic        m_tx_en = 1'b0;
    logic        m_rr = 1'b0;
    logic [10:0] m_size = 11'd0;

    always #5 clk = ~clk;

    eth_tx_sched_if bus();
    assign bus.i_req      = {req1, req0};
    assign bus.i_size0    = size0;
    assign bus.i_size1    = size1;
    assign bus.i_tx_ready = eng_ready;

    eth_tx_sched dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .io_bus  (bus)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Engine: mode 0 drops ready after a start and raises it eng_len clocks later,
    // mode 1 ignores starts, mode 2 drops ready and never raises it.
    initial forever begin
        @(negedge clk);
        #1;
        if (!eng_ready) begin
            if (eng_mode != 2) begin
                if (eng_left > 1) eng_left--;
                else eng_ready = 1'b1;
            end
        end else if (bus.o_tx_en && eng_mode != 1) begin
            eng_ready = 1'b0;
            eng_left  = eng_rand ? int'($urandom_range(40, 2)) : eng_len;
        end
    end

    task automatic m_step(output bit rst_hit);
        @(posedge clk or negedge rst_n);
        rst_hit = !rst_n;
        m_ack   = 2'b00;
        m_err   = 2'b00;
        m_tx_en = 1'b0;
    endtask

    // One arbitration attempt and, if accepted, the whole frame timeline.
    task automatic m_frame();
        bit r;
        bit ok;
        logic g;
        m_step(r);
        if (r) return;
        if (bus.i_req == 2'b00 || !eng_ready) return;
        g       = (bus.i_req == 2'b11) ? m_rr : bus.i_req[1];
        m_grant = g;
        m_size  = g ? size1 : size0;
        if (m_size == 11'd0 || m_size > 11'd1500) begin
            m_err = g ? 2'b10 : 2'b01;
            m_rr  = !g;
            return;
        end
        m_busy  = 1'b1;
        m_tx_en = 1'b1;
        m_step(r);
        if (r) return;
        ok = 1'b0;
        for (int n = 1; n <= 4; n++) begin
            m_step(r);
            if (r) return;
            if (!eng_ready) begin ok = 1'b1; break; end
        end
        if (!ok) begin
            m_err = g ? 2'b10 : 2'b01;
        end else begin
            ok = 1'b0;
            for (int n = 1; n <= 4000; n++) begin
                m_step(r);
                if (r) return;
                if (eng_ready) begin ok = 1'b1; break; end
            end
            if (ok) m_ack = g ? 2'b10 : 2'b01;
            else    m_err = g ? 2'b10 : 2'b01;
        end
        for (int n = 1; n <= 48; n++) begin
            m_step(r);
            if (r) return;
        end
        m_busy = 1'b0;
        m_rr   = !g;
    endtask

    initial forever begin
        if (!rst_n) begin
            m_ack = 2'b00; m_err = 2'b00; m_busy = 1'b0; m_grant = 1'b0;
            m_tx_en = 1'b0; m_rr = 1'b0; m_size = 11'd0;
            wait (rst_n);
        end
        m_frame();
    end

    initial forever begin
        @(negedge clk);
        cyc++;
        if (bus.o_tx_en) n_tx_en++;
        check("ack", bus.o_ack, m_ack);
        check("err", bus.o_err, m_err);
        check("busy", bus.o_busy, m_busy);
        check("tx_en", bus.o_tx_en, m_tx_en);
        check("grant", bus.o_grant, m_grant);
        check("ram_bank", bus.o_ram_bank, m_grant);
        check("tx_size", bus.o_tx_size, m_size);
        check("pulse_onehot", $countones(bus.o_ack | bus.o_err) <= 1, 1);
    end

    task automatic tick();
        @(negedge clk);
        #2;
    endtask

    task automatic wait_tx_en(output int t);
        int n = 0;
        do begin tick(); n++; end while (!bus.o_tx_en && n < 6000);
        check("tx_en_seen", bus.o_tx_en, 1);
        t = cyc;
    endtask

    task automatic wait_pulse(output logic [1:0] a, output logic [1:0] e, output int t);
        int n = 0;
        do begin tick(); n++; end while ((bus.o_ack | bus.o_err) == 2'b00 && n < 6000);
        check("pulse_seen", |(bus.o_ack | bus.o_err), 1);
        a = bus.o_ack;
        e = bus.o_err;
        t = cyc;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (bus.o_busy && n < 6000) begin tick(); n++; end
        check("idle_reached", bus.o_busy, 0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (3) tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic rand_source(input int s);
        logic [10:0] sz;
        bit got;
        bit started;
        int n;
        for (int k = 0; k < 25; k++) begin
            repeat ($urandom_range(30, 0)) tick();
            case ($urandom_range(7, 0))
                0:       sz = 11'd0;
                1:       sz = 11'($urandom_range(2047, 1501));
                default: sz = 11'($urandom_range(1500, 1));
            endcase
            if (s == 0) begin size0 = sz; req0 = 1'b1; end
            else        begin size1 = sz; req1 = 1'b1; end
            got = 1'b0;
            started = 1'b0;
            n = 0;
            while (!got && n < 6000) begin
                tick();
                n++;
                if (bus.o_ack[s] || bus.o_err[s]) got = 1'b1;
                else begin
                    if (bus.o_tx_en && bus.o_grant == s[0]) started = 1'b1;
                    if (started && $urandom_range(15, 0) == 0) begin
                        if (s == 0) req0 = 1'b0; else req1 = 1'b0;
                    end
                end
            end
            check(s == 0 ? "src0_done" : "src1_done", got, 1);
            if (s == 0) req0 = 1'b0; else req1 = 1'b0;
        end
    endtask

    initial begin
        int t0, t1, t2, k, c0;
        bit ok;
        logic [1:0] a, e;

        tick();
        tick();
        check("rst_busy", bus.o_busy, 0);
        check("rst_grant", bus.o_grant, 0);
        check("rst_ack_err", {bus.o_ack, bus.o_err}, 0);
        check("rst_tx", {bus.o_tx_en, bus.o_tx_size, bus.o_ram_bank}, 0);
        rst_n = 1'b1;
        tick();

        // Single frame from source 0.
        eng_len = 300; size0 = 11'd64; req0 = 1'b1;
        wait_tx_en(t0);
        c0 = n_tx_en;
        check("t1_size", bus.o_tx_size, 64);
        check("t1_bank", bus.o_ram_bank, 0);
        wait_pulse(a, e, t1);
        req0 = 1'b0;
        check("t1_ack", a, 2'b01);
        check("t1_err", e, 2'b00);
        check("t1_frame_time", t1 - t0, 301);
        check("t1_single_start", n_tx_en - c0, 0);
        k = 0;
        while (bus.o_busy && k < 100) begin tick(); k++; end
        check("t1_ifg", k, 48);

        // Both sources holding requests: strict alternation.
        do_reset();
        eng_len = 200; size0 = 11'd100; size1 = 11'd200; req0 = 1'b1; req1 = 1'b1;
        t2 = 0;
        for (int i = 0; i < 4; i++) begin
            wait_tx_en(t0);
            check("t2_grant", bus.o_grant, i % 2);
            check("t2_size", bus.o_tx_size, (i % 2) ? 200 : 100);
            if (i > 0) check("t2_gap", t0 - t2, 250);
            t2 = t0;
        end
        req0 = 1'b0; req1 = 1'b0;
        wait_idle();

        // Size rejection and the upper boundary.
        eng_len = 20;
        c0 = n_tx_en;
        size1 = 11'd0; req1 = 1'b1; t0 = cyc;
        wait_pulse(a, e, t1);
        req1 = 1'b0;
        check("t3_err_zero", e, 2'b10);
        check("t3_err_latency", t1 - t0, 1);
        tick();
        size1 = 11'd1501; req1 = 1'b1;
        wait_pulse(a, e, t1);
        req1 = 1'b0;
        check("t3_err_big", e, 2'b10);
        check("t3_ack_big", a, 2'b00);
        check("t3_no_start", n_tx_en - c0, 0);
        tick();
        size1 = 11'd1500; req1 = 1'b1;
        wait_pulse(a, e, t1);
        req1 = 1'b0;
        check("t3_max_ack", a, 2'b10);
        check("t3_max_starts", n_tx_en - c0, 1);
        wait_idle();

        // Engine timeouts.
        eng_mode = 1; size0 = 11'd64; req0 = 1'b1;
        wait_tx_en(t0);
        wait_pulse(a, e, t1);
        req0 = 1'b0;
        check("t4_busy_err", e, 2'b01);
        check("t4_busy_time", t1 - t0, 5);
        k = 0;
        while (bus.o_busy && k < 100) begin tick(); k++; end
        check("t4_ifg", k, 48);
        eng_mode = 2; eng_len = 2; req0 = 1'b1;
        wait_tx_en(t0);
        wait_pulse(a, e, t1);
        req0 = 1'b0;
        check("t4_done_err", e, 2'b01);
        check("t4_done_time", t1 - t0, 4002);
        eng_mode = 0;
        wait_idle();
        repeat (5) tick();

        // Async reset mid-frame, then wait for engine ready before re-grant.
        eng_len = 300; size1 = 11'd64; req1 = 1'b1;
        wait_tx_en(t0);
        repeat (100) tick();
        rst_n = 1'b0;
        #1;
        check("t5_rst_busy", bus.o_busy, 0);
        check("t5_rst_grant", {bus.o_grant, bus.o_ram_bank}, 0);
        check("t5_rst_size", bus.o_tx_size, 0);
        check("t5_rst_pulses", {bus.o_tx_en, bus.o_ack, bus.o_err}, 0);
        tick();
        rst_n = 1'b1;
        ok = 1'b1;
        k = 0;
        while (!eng_ready && k < 1000) begin
            tick();
            k++;
            if (bus.o_busy || bus.o_tx_en) ok = 1'b0;
        end
        check("t5_no_grant_while_engine_busy", ok, 1);
        check("t5_engine_was_busy", k > 100, 1);
        wait_tx_en(t0);
        check("t5_grant", bus.o_grant, 1);
        wait_pulse(a, e, t1);
        req1 = 1'b0;
        check("t5_ack", a, 2'b10);
        wait_idle();

        // Request dropped mid-frame while the other source arrives.
        eng_len = 100; size0 = 11'd64; req0 = 1'b1;
        wait_tx_en(t0);
        repeat (10) tick();
        req0 = 1'b0; size1 = 11'd80; req1 = 1'b1;
        wait_pulse(a, e, t1);
        check("t6_ack0", a, 2'b01);
        wait_tx_en(t2);
        check("t6_grant1", bus.o_grant, 1);
        check("t6_after_ifg", t2 - t1, 49);
        wait_pulse(a, e, t1);
        req1 = 1'b0;
        check("t6_ack1", a, 2'b10);
        wait_idle();

        // Randomized traffic against the model.
        eng_rand = 1'b1;
        fork
            rand_source(0);
            rand_source(1);
        join
        wait_idle();
        repeat (60) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
